// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between the I-side fetch and D-side data requesters
//
// Latches one request at a time and holds it on the memory port until
// mem_resp. D-side wins arbitration by default. I-side is forced through
// after STARVE_LIMIT consecutive D grants made while it was waiting.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   i_read, i_address               I-side read request / address
//   i_rdata, i_resp                 I-side read data / one-cycle completion
//   d_read, d_write                 D-side read / write request (both = write)
//   d_address, d_wdata              D-side address / write data
//   d_rdata, d_resp                 D-side read data / one-cycle completion
//   mem_read, mem_write             registered memory strobes
//   mem_address, mem_wdata          latched memory address / write data
//   mem_rdata, mem_resp             memory read data / completion
//   busy, grant_d                   transaction in flight / owned by D-side

module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy,
  output logic              grant_d
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam bit STARVE_EN = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;

  logic d_pend;
  logic i_wins;

  assign d_pend = d_read | d_write;
  // I-side goes first when D is idle, or when it has waited out LIMIT D grants.
  assign i_wins = i_read & (~d_pend | (STARVE_EN & (starve_cnt == LIMIT)));

  // Completion is reported in the same cycle mem_resp arrives; read data is
  // gated so each side sees zero outside its own response cycle.
  assign i_resp  = (state == SERVE_I) & mem_resp;
  assign d_resp  = (state == SERVE_D) & mem_resp;
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      grant_d     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_wins) begin
            state       <= SERVE_I;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
            mem_address <= i_address;
            mem_wdata   <= '0;
            busy        <= 1'b1;
            grant_d     <= 1'b0;
            starve_cnt  <= '0;
          end else if (d_pend) begin
            state       <= SERVE_D;
            // Read+write together is treated as a write.
            mem_read    <= ~d_write;
            mem_write   <= d_write;
            mem_address <= d_address;
            mem_wdata   <= d_wdata;
            busy        <= 1'b1;
            grant_d     <= 1'b1;
            if (!i_read) begin
              starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            grant_d   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          busy      <= 1'b0;
          grant_d   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read;
  logic [15:0] i_address;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        busy;
  logic        grant_d;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {16'(i_rdata), 16'(d_rdata)}, 32'h0);
    check({tag, "_strb"}, {26'h0, i_resp, d_resp, mem_read, mem_write, busy, grant_d}, 32'h0);
    check({tag, "_madr"}, {16'(mem_address), 16'(mem_wdata)}, 32'h0);
  endtask

  initial begin
    // Reset with random request inputs
    rst_n     = 1'b0;
    i_read    = 1'($urandom);
    i_address = 16'($urandom);
    d_read    = 1'($urandom);
    d_write   = 1'($urandom);
    d_address = 16'($urandom);
    d_wdata   = 16'($urandom);
    mem_rdata = 16'($urandom);
    mem_resp  = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    i_read = 0; d_read = 0; d_write = 0; mem_rdata = 0;
    rst_n = 1'b1;
    tick();
    check("post_reset_busy", 32'(busy), 32'h0);

    // I-only read, with latch-stability disturbance during SERVE_I
    i_read = 1; i_address = 16'h0040;
    tick();
    check("iread_strb", {30'h0, mem_read, mem_write}, 32'h2);
    check("iread_addr", 32'(mem_address), 32'h0040);
    check("iread_owner", {30'h0, busy, grant_d}, 32'h2);
    i_address = 16'h7FFE; d_write = 1; d_address = 16'h0999;
    tick();
    check("latch_addr", 32'(mem_address), 32'h0040);
    check("latch_wr", {30'h0, mem_read, mem_write}, 32'h2);
    tick();
    mem_resp = 1; mem_rdata = 16'h1234;
    i_read = 0; d_write = 0;
    #1;
    check("iread_resp", {30'h0, i_resp, d_resp}, 32'h2);
    check("iread_rdata", {16'(i_rdata), 16'(d_rdata)}, {16'h1234, 16'h0});
    tick();
    mem_resp = 0;
    #1;
    check("iread_done", {28'h0, busy, mem_read, i_resp, d_resp}, 32'h0);

    // Contention: D write wins, then I read
    i_read = 1; i_address = 16'h0100;
    d_write = 1; d_address = 16'h0200; d_wdata = 16'hBEEF;
    tick();
    check("cont_d_strb", {29'h0, mem_read, mem_write, grant_d}, 32'h3);
    check("cont_d_bus", {16'(mem_address), 16'(mem_wdata)}, {16'h0200, 16'hBEEF});
    mem_resp = 1; mem_rdata = 16'h0;
    d_write = 0;
    #1;
    check("cont_d_resp", {30'h0, i_resp, d_resp}, 32'h1);
    tick();
    mem_resp = 0;
    check("cont_idle", 32'(busy), 32'h0);
    tick();
    check("cont_i_strb", {29'h0, mem_read, mem_write, grant_d}, 32'h4);
    check("cont_i_addr", 32'(mem_address), 32'h0100);
    mem_resp = 1; mem_rdata = 16'h5A5A;
    i_read = 0;
    #1;
    check("cont_i_resp", {30'h0, i_resp, d_resp}, 32'h2);
    check("cont_i_rdata", 32'(i_rdata), 32'h5A5A);
    tick();
    mem_resp = 0;

    // Starvation: four D grants, then I forced on the fifth arbitration
    i_read = 1; i_address = 16'h0300;
    d_read = 1;
    for (int k = 0; k < 5; k++) begin
      d_address = 16'h0400 + 16'(k);
      tick();
      check($sformatf("starve_owner%0d", k), 32'(grant_d), (k < 4) ? 32'h1 : 32'h0);
      check($sformatf("starve_addr%0d", k), 32'(mem_address),
            (k < 4) ? (32'h0400 + 32'(k)) : 32'h0300);
      mem_resp = 1; mem_rdata = 16'h0A00 + 16'(k);
      #1;
      check($sformatf("starve_resp%0d", k), {30'h0, i_resp, d_resp},
            (k < 4) ? 32'h1 : 32'h2);
      tick();
      mem_resp = 0;
    end
    // Counter cleared by the I grant: D wins again with both pending
    d_address = 16'h0500;
    tick();
    check("starve_clear", {31'h0, grant_d}, 32'h1);
    check("starve_clear_addr", 32'(mem_address), 32'h0500);
    mem_resp = 1;
    i_read = 0; d_read = 0;
    tick();
    mem_resp = 0;
    tick();

    // Reset mid-transaction, then stale response in IDLE
    d_write = 1; d_address = 16'h0010; d_wdata = 16'h1111;
    tick();
    check("rst_mid_pre", 32'(mem_write), 32'h1);
    rst_n = 0;
    #1;
    check("rst_mid_drop", {30'h0, mem_write, busy}, 32'h0);
    d_write = 0;
    tick();
    check_all_zero("rst_mid");
    rst_n = 1;
    tick();
    mem_resp = 1; mem_rdata = 16'hDEAD;
    #1;
    check("stale_resp", {30'h0, i_resp, d_resp}, 32'h0);
    check("stale_rdata", {16'(i_rdata), 16'(d_rdata)}, 32'h0);
    tick();
    mem_resp = 0;
    check("stale_idle", {29'h0, busy, mem_read, mem_write}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one physical memory port between the CPU instruction-fetch requester (I-side, read-only) and the MEM-stage data requester (D-side, read/write).
- Sits between the CPU's two memory ports and the single memory/cache interface.
- Latches one request at a time and holds it stable until memory responds.
- D-side has priority by default, with a bounded-starvation guarantee for I-side.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- STARVE_LIMIT, 4, max consecutive D grants while I is pending before I is forced; 0 disables (pure D priority).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  I-side read request, held until i_resp.
- i_address  in  ADDR_W  I-side address.
- i_rdata  out  DATA_W  I-side read data, valid with i_resp.
- i_resp  out  1  I-side completion, one-cycle pulse.
- d_read  in  1  D-side read request.
- d_write  in  1  D-side write request.
- d_address  in  ADDR_W  D-side address.
- d_wdata  in  DATA_W  D-side write data.
- d_rdata  out  DATA_W  D-side read data, valid with d_resp.
- d_resp  out  1  D-side completion, one-cycle pulse.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_W  memory address (latched).
- mem_wdata  out  DATA_W  memory write data (latched).
- mem_rdata  in  DATA_W  memory read data.
- mem_resp  in  1  memory completion.
- busy  out  1  transaction in flight.
- grant_d  out  1  in-flight transaction belongs to D-side.

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. State register uses async reset to IDLE.
- Reset values: all outputs 0, starve counter 0, latched address/data/op 0. Reset asserted mid-transaction drops mem_read/mem_write immediately. The in-flight request is abandoned and no resp pulse is issued.
- IDLE arbitration on the registered cycle edge:
  - Only I pending: grant I.
  - D pending (d_read|d_write), I not pending: grant D.
  - Both pending: grant I if STARVE_LIMIT≠0 and starve_cnt==STARVE_LIMIT; else grant D.
  - On the grant edge, latch address, wdata and op (read/write).
  - Move to SERVE_I or SERVE_D.
- D-side read and write both asserted is illegal; it is treated as a write.
- Starve counter:
  - On a D grant with i_read high: increments, saturating at STARVE_LIMIT.
  - On a D grant with i_read low: clears.
  - On any I grant: clears.
- SERVE_x outputs:
  - mem_read/mem_write, mem_address and mem_wdata are driven from the latched values. Requester input changes are ignored until completion.
  - busy=1; grant_d=1 in SERVE_D only.
- Completion:
  - Cycle with mem_resp=1 in SERVE_x: x_resp=1 combinationally that cycle; x_rdata=mem_rdata.
  - Next edge: return to IDLE, strobes drop.
  - Other requester's resp stays 0. Its rdata is 0 outside its own response cycle.
- Latency: request first seen high in IDLE at cycle t gives memory strobe at t+1. Completion cycle r is followed by IDLE at r+1, and a new grant can appear at r+2. Minimum 3 cycles per access with 1-cycle memory.
- Requester deasserting mid-transaction: the transaction still completes and resp still pulses. The requester discards it.
- mem_resp while in IDLE (stale/spurious) is ignored. No resp pulse, no state change.
- No combinational path from requester inputs to mem_* outputs; all mem_* outputs are registered/latched.

Test Plan:
- Reset: drive rst_n=0 with random inputs -> all outputs 0. Release rst_n -> state IDLE, busy=0.
- I-only read: i_read=1, i_address=0x0040; memory responds 3 cycles later with 0x1234 -> mem_read=1 and mem_address=0x0040 the cycle after the request; i_resp pulses exactly once with i_rdata=0x1234; busy=0 the following cycle; d_resp stays 0.
- Contention: same cycle, i_read@0x0100 and d_write@0x0200 with d_wdata=0xBEEF -> D served first (mem_write=1, mem_address=0x0200, mem_wdata=0xBEEF, d_resp pulse), then I read of 0x0100 with i_resp.
- Starvation, STARVE_LIMIT=4: i_read held high, D re-requests immediately after each d_resp -> exactly 4 D transactions, then I granted on the 5th arbitration; the counter clears afterwards.
- Latch stability: during SERVE_I change i_address 0x0040→0x7FFE and raise d_write -> mem_address stays 0x0040 and mem_write stays 0 until mem_resp.
- Reset mid-op and stale response: assert rst_n=0 during SERVE_D -> mem_write=0 immediately. After release, drive mem_resp=1 in IDLE -> no d_resp/i_resp, state remains IDLE.
